colour_scheduler: RTL

Shares one colour converter (3-bit colour in, 24-bit RGB out, registered with enable) between two requesters. Round-robin arbitration with valid/ready handshakes on each request port. Sequences the converter: issues the colour with a one-cycle enable, waits the converter latency, then captures the RGB. Returns the RGB to the winner on a valid/ready response channel tagged with the requester ID.

---
 rtl/colour_scheduler_pkg.sv | 22 ++
 rtl/colour_scheduler_rr_arbiter_2.sv | 24 ++
 rtl/colour_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/colour_scheduler_pkg.sv
// Shared definitions for the colour scheduler slice.
//   - state_t         : scheduler FSM states
//   - COLOUR_W, RGB_W : converter data widths
//   - ID_W            : requester ID width (two requesters)
//   - CONV_LAT_DEFAULT: default converter latency in cycles
//   - WAIT_CNT_W      : width of the latency wait counter (covers 1..15)
package colour_scheduler_pkg;

    localparam int unsigned COLOUR_W         = 3;
    localparam int unsigned RGB_W            = 24;
    localparam int unsigned ID_W             = 1;
    localparam int unsigned CONV_LAT_DEFAULT = 1;
    localparam int unsigned WAIT_CNT_W       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

endpackage

// File: rtl/colour_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid   in  2  request valids, bit N for requester N
//   last_id in  1  ID of the requester served most recently
//   grant   out 2  one-hot grant (all zero when no valid)
// With a single valid that requester wins; with both valid the one not served last wins.
module colour_scheduler_rr_arbiter_2
    import colour_scheduler_pkg::*;
(
    input  logic [1:0]      valid,
    input  logic [ID_W-1:0] last_id,
    output logic [1:0]      grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last_id == 1'b1)) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/colour_scheduler.sv
// Shares one registered colour converter between two requesters.
// A round-robin arbiter picks a requester while idle; the colour is issued to the converter
// with a one-cycle enable, the converter latency is waited out, and the captured RGB is
// returned on a valid/ready response channel tagged with the requester ID.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/colour/ready     request channel of requester N (ready only while idle)
//   resp_valid/id/rgb/ready     response channel, held stable until accepted
//   conv_colour, conv_enable    converter drive (enable is a one-cycle pulse)
//   conv_rgb                    converter result, sampled CONV_LAT cycles after enable
//   busy                        high whenever the FSM is not idle
//   served_cnt                  completed responses, wraps
module colour_scheduler
    import colour_scheduler_pkg::*;
#(
    parameter int unsigned CONV_LAT = CONV_LAT_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [COLOUR_W-1:0] req0_colour,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [COLOUR_W-1:0] req1_colour,
    output logic                req1_ready,
    output logic                resp_valid,
    output logic [ID_W-1:0]     resp_id,
    output logic [RGB_W-1:0]    resp_rgb,
    input  logic                resp_ready,
    output logic [COLOUR_W-1:0] conv_colour,
    output logic                conv_enable,
    input  logic [RGB_W-1:0]    conv_rgb,
    output logic                busy,
    output logic [CNT_W-1:0]    served_cnt
);

    state_t                state;
    logic [ID_W-1:0]       last_id;
    logic [ID_W-1:0]       cap_id;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [1:0]            grant;

    colour_scheduler_rr_arbiter_2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .last_id (last_id),
        .grant   (grant)
    );

    // Readiness is gated by rst_n so every output reads 0 while reset is held.
    assign req0_ready = rst_n && (state == StIdle) && grant[0];
    assign req1_ready = rst_n && (state == StIdle) && grant[1];
    assign busy       = (state != StIdle);
    assign resp_id    = cap_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            last_id     <= 1'b1;  // pretend req1 was served last so req0 wins first contention
            cap_id      <= '0;
            wait_cnt    <= '0;
            conv_colour <= '0;
            conv_enable <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rgb    <= '0;
            served_cnt  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // conv_colour doubles as the captured colour; it is stable until next issue.
                    if (grant != 2'b00) begin
                        cap_id      <= grant[1];
                        conv_colour <= grant[1] ? req1_colour : req0_colour;
                        conv_enable <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    conv_enable <= 1'b0;
                    wait_cnt    <= WAIT_CNT_W'(CONV_LAT - 1);
                    state       <= StWait;
                end
                StWait: begin
                    if (wait_cnt == '0) begin
                        resp_rgb   <= conv_rgb;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        last_id    <= cap_id;
                        served_cnt <= served_cnt + CNT_W'(1);
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
